// File: rtl/fp_adder_pkg.sv
// Shared definitions for the single-precision FP adder pipeline.
// Holds operand field widths, EData class codes and the align FSM states.
package fp_adder_pkg;

  localparam int UNP_W     = 37;
  localparam int MANT_W    = 28;
  localparam int EXP_W     = 8;
  localparam int SAT_SHIFT = 27;

  typedef enum logic [1:0] {
    ED_ZERO = 2'b00,
    ED_NORM = 2'b01,
    ED_MIX  = 2'b10
  } edata_t;

  typedef enum logic [1:0] {
    ALIGN_IDLE,
    ALIGN_SHIFT,
    ALIGN_DONE
  } align_state_t;

  // Denormals behave as if their exponent were 1.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/fp_mag_compare.sv
// Combinational magnitude ordering of two unpacked operands.
// Produces the swap decision, the exponent gap and the common exponent.
module fp_mag_compare
  import fp_adder_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_b,
  output logic              swap,
  output logic [EXP_W-1:0]  d,
  output logic [EXP_W-1:0]  eff_big
);

  logic [EXP_W-1:0]        eff_a;
  logic [EXP_W-1:0]        eff_b;
  logic [EXP_W+MANT_W-1:0] key_a;
  logic [EXP_W+MANT_W-1:0] key_b;

  assign eff_a = eff_exp(exp_a);
  assign eff_b = eff_exp(exp_b);
  assign key_a = {eff_a, mant_a};
  assign key_b = {eff_b, mant_b};

  // Ties keep A as the big operand.
  assign swap    = (key_b > key_a);
  assign d       = swap ? (eff_b - eff_a) : (eff_a - eff_b);
  assign eff_big = swap ? eff_b : eff_a;

endmodule

// File: rtl/fp_align_stage.sv
// Exponent-alignment stage: orders operands by magnitude and iteratively
// right-shifts the smaller significand by STEP bits per cycle with sticky.
module fp_align_stage
  import fp_adder_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [UNP_W-1:0]  NA,
  input  logic [UNP_W-1:0]  NB,
  input  logic [1:0]        EData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_big,
  output logic              sign_small,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              swapped,
  output logic              special,
  output logic [1:0]        edata_out
);

  localparam logic [4:0] STEP_V = 5'(STEP);

  align_state_t      state;
  align_state_t      state_next;
  logic [4:0]        rem;
  logic              swap;
  logic [EXP_W-1:0]  d;
  logic [EXP_W-1:0]  eff_big;
  logic              no_shift;
  logic              saturate;
  logic [MANT_W-1:0] small_in;
  logic [4:0]        s;
  logic [MANT_W-1:0] shift_mask;
  logic [MANT_W-1:0] shifted;

  fp_mag_compare u_cmp (
    .exp_a   (NA[35:28]),
    .mant_a  (NA[MANT_W-1:0]),
    .exp_b   (NB[35:28]),
    .mant_b  (NB[MANT_W-1:0]),
    .swap    (swap),
    .d       (d),
    .eff_big (eff_big)
  );

  assign no_shift = (d == '0);
  assign saturate = (d >= EXP_W'(SAT_SHIFT));
  assign small_in = swap ? NA[MANT_W-1:0] : NB[MANT_W-1:0];

  // Every bit leaving the bottom, including an already-set sticky, folds into bit 0.
  always_comb begin
    s          = (rem > STEP_V) ? STEP_V : rem;
    shift_mask = (MANT_W'(1) << s) - MANT_W'(1);
    shifted    = mant_small >> s;
    shifted[0] = shifted[0] | (|(mant_small & shift_mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ALIGN_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ALIGN_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (no_shift || saturate) ? ALIGN_DONE : ALIGN_SHIFT;
      end
      ALIGN_SHIFT: begin
        if (rem <= STEP_V) state_next = ALIGN_DONE;
      end
      ALIGN_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ALIGN_IDLE;
      end
      default: state_next = ALIGN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_out    <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      swapped    <= 1'b0;
      special    <= 1'b0;
      edata_out  <= '0;
      rem        <= '0;
    end else begin
      case (state)
        ALIGN_IDLE: begin
          if (in_valid) begin
            sign_big   <= swap ? NB[36] : NA[36];
            sign_small <= swap ? NA[36] : NB[36];
            exp_out    <= eff_big;
            mant_big   <= swap ? NB[MANT_W-1:0] : NA[MANT_W-1:0];
            swapped    <= swap;
            special    <= (NA[35:28] == 8'hFF) || (NB[35:28] == 8'hFF);
            edata_out  <= EData;
            if (saturate) begin
              mant_small <= {{(MANT_W-1){1'b0}}, |small_in};
              rem        <= '0;
            end else begin
              mant_small <= small_in;
              rem        <= d[4:0];
            end
          end
        end
        ALIGN_SHIFT: begin
          mant_small <= shifted;
          rem        <= rem - s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed self-checking bench for fp_align_stage with STEP=4.
// Each scenario task drives operands and compares against hand-computed values.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [36:0] na = '0;
  logic [36:0] nb = '0;
  logic [1:0]  edata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_big, sign_small, swapped, special;
  logic [7:0]  exp_out;
  logic [27:0] mant_big, mant_small;
  logic [1:0]  edata_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_align_stage #(.STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .NA         (na),
    .NB         (nb),
    .EData      (edata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .exp_out    (exp_out),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .swapped    (swapped),
    .special    (special),
    .edata_out  (edata_out)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] unpack(input logic [31:0] w);
    return {w[31], w[30:23], |w[30:23], w[22:0], 4'b0000};
  endfunction

  // Presents one op while idle and counts edges from accept until out_valid.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ed, output int lat);
    na = unpack(a); nb = unpack(b); edata = ed; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; na = '0; nb = '0; edata = '0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if ({exp_out, mant_big, mant_small} !== '0) begin n_fail++; $display("[TB] FAIL reset_outputs got %h/%h/%h want 0", exp_out, mant_big, mant_small); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_equal();
    int lat;
    send_op(32'h3F800000, 32'h3F800000, 2'b01, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL eq_latency got %0d want 1", lat); end
    n_checks++; if (exp_out !== 8'h7F) begin n_fail++; $display("[TB] FAIL eq_exp got %h want 7f", exp_out); end
    n_checks++; if (mant_big !== 28'h8000000) begin n_fail++; $display("[TB] FAIL eq_mant_big got %h want 8000000", mant_big); end
    n_checks++; if (mant_small !== 28'h8000000) begin n_fail++; $display("[TB] FAIL eq_mant_small got %h want 8000000", mant_small); end
    n_checks++; if (swapped !== 1'b0) begin n_fail++; $display("[TB] FAIL eq_swapped got %b want 0", swapped); end
    n_checks++; if (edata_out !== 2'b01) begin n_fail++; $display("[TB] FAIL eq_edata got %b want 01", edata_out); end
    release_out();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL eq_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_swap_d1();
    int lat;
    send_op(32'h3F800000, 32'h40000000, 2'b01, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL d1_latency got %0d want 2", lat); end
    n_checks++; if (swapped !== 1'b1) begin n_fail++; $display("[TB] FAIL d1_swapped got %b want 1", swapped); end
    n_checks++; if (exp_out !== 8'h80) begin n_fail++; $display("[TB] FAIL d1_exp got %h want 80", exp_out); end
    n_checks++; if (mant_big !== 28'h8000000) begin n_fail++; $display("[TB] FAIL d1_mant_big got %h want 8000000", mant_big); end
    n_checks++; if (mant_small !== 28'h4000000) begin n_fail++; $display("[TB] FAIL d1_mant_small got %h want 4000000", mant_small); end
    release_out();
  endtask

  task automatic test_sticky_d10();
    int lat;
    send_op(32'h44800000, 32'h3F800001, 2'b01, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("[TB] FAIL d10_latency got %0d want 4", lat); end
    n_checks++; if (mant_small !== 28'h0020001) begin n_fail++; $display("[TB] FAIL d10_mant_small got %h want 0020001", mant_small); end
    n_checks++; if (exp_out !== 8'h89 || swapped !== 1'b0) begin n_fail++; $display("[TB] FAIL d10_exp_swap got %h/%b want 89/0", exp_out, swapped); end
    release_out();
  endtask

  task automatic test_saturate();
    int lat;
    send_op(32'h3F800000, 32'h30800000, 2'b01, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL sat_latency got %0d want 1", lat); end
    n_checks++; if (mant_small !== 28'h0000001) begin n_fail++; $display("[TB] FAIL sat_mant_small got %h want 0000001", mant_small); end
    n_checks++; if (exp_out !== 8'h7F) begin n_fail++; $display("[TB] FAIL sat_exp got %h want 7f", exp_out); end
    release_out();
  endtask

  task automatic test_denormal_mix();
    int lat;
    send_op(32'h00000001, 32'h00800000, 2'b10, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL mix_latency got %0d want 1", lat); end
    n_checks++; if (swapped !== 1'b1) begin n_fail++; $display("[TB] FAIL mix_swapped got %b want 1", swapped); end
    n_checks++; if (exp_out !== 8'h01) begin n_fail++; $display("[TB] FAIL mix_exp got %h want 01", exp_out); end
    n_checks++; if (mant_small !== 28'h0000010) begin n_fail++; $display("[TB] FAIL mix_mant_small got %h want 0000010", mant_small); end
    n_checks++; if (edata_out !== 2'b10) begin n_fail++; $display("[TB] FAIL mix_edata got %b want 10", edata_out); end
    release_out();
  endtask

  // Exact-multiple shift, last non-saturating gap, first saturating gap, Inf operand, signs.
  task automatic test_boundaries();
    logic [31:0] ta [5] = '{32'h43800000, 32'h4C800000, 32'h4D000000, 32'h7F800000, 32'hC0000000};
    logic [31:0] tb [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    int          tl [5] = '{3, 8, 1, 1, 2};
    logic [7:0]  te [5] = '{8'h87, 8'h99, 8'h9A, 8'hFF, 8'h80};
    logic [27:0] tm [5] = '{28'h0080000, 28'h0000002, 28'h0000001, 28'h0000001, 28'h4000000};
    logic [2:0]  tf [5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b100};
    int lat;
    for (int i = 0; i < 5; i++) begin
      send_op(ta[i], tb[i], 2'b01, lat);
      n_checks++; if (lat !== tl[i]) begin n_fail++; $display("[TB] FAIL bnd%0d_latency got %0d want %0d", i, lat, tl[i]); end
      n_checks++; if (exp_out !== te[i]) begin n_fail++; $display("[TB] FAIL bnd%0d_exp got %h want %h", i, exp_out, te[i]); end
      n_checks++; if (mant_small !== tm[i]) begin n_fail++; $display("[TB] FAIL bnd%0d_mant_small got %h want %h", i, mant_small, tm[i]); end
      n_checks++; if ({sign_big, sign_small, special} !== tf[i]) begin n_fail++; $display("[TB] FAIL bnd%0d_flags got %b want %b", i, {sign_big, sign_small, special}, tf[i]); end
      release_out();
    end
  endtask

  task automatic test_hold();
    int lat;
    send_op(32'h3F800000, 32'h3F800000, 2'b01, lat);
    na = unpack(32'h3F800000); nb = unpack(32'h30800000); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold%0d_handshake got vld=%b rdy=%b want 1/0", i, out_valid, in_ready); end
      n_checks++; if (mant_small !== 28'h8000000 || exp_out !== 8'h7F) begin n_fail++; $display("[TB] FAIL hold%0d_data got %h/%h want 8000000/7f", i, mant_small, exp_out); end
    end
    in_valid = 1'b0;
    release_out();
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    na = unpack(32'h44800000); nb = unpack(32'h3F800001); edata = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_handshake got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (mant_small !== '0 || exp_out !== '0 || edata_out !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_outputs got %h/%h/%b want 0", mant_small, exp_out, edata_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL rst_mid_no_output got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send_op(32'h3F800000, 32'h40000000, 2'b01, lat);
    release_out();
    send_op(32'h3F800000, 32'h30800000, 2'b00, lat);
    n_checks++; if (lat !== 1 || mant_small !== 28'h0000001) begin n_fail++; $display("[TB] FAIL b2b_second got lat=%0d mant=%h want 1/0000001", lat, mant_small); end
    n_checks++; if (edata_out !== 2'b00 || swapped !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_fields got %b/%b want 00/0", edata_out, swapped); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_swap_d1();
    test_sticky_d10();
    test_saturate();
    test_denormal_mix();
    test_boundaries();
    test_hold();
    test_reset_mid_shift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

endmodule
